// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   WORD_SIZE     : datapath / address width
//   NOP_OP        : opcode field of the no-operation instruction
//   NOP_INST      : full NOP encoding {NOP_OP, 12'b0}
//   fetch_state_t : FETCH / HOLD state encoding
package if_fetch_unit_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [3:0]           NOP_OP   = 4'hF;
    localparam logic [WORD_SIZE-1:0] NOP_INST = {NOP_OP, 12'b0};

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_fetch_btb.sv
// Direct-mapped branch target buffer for the fetch stage.
// Lookup is combinational; updates land on the rising edge, so a write to
// the entry being looked up becomes visible one cycle later.
// Ports:
//   clk, reset_n            : clock, async active-high reset (clears valid bits)
//   lookup_pc               : PC being fetched
//   hit, hit_target         : lookup result
//   upd_en, upd_pc, upd_tgt : record a taken branch
module fetch_btb #(
    parameter int WORD_SIZE = 16,
    parameter int ENTRIES   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] lookup_pc,
    output logic                 hit,
    output logic [WORD_SIZE-1:0] hit_target,
    input  logic                 upd_en,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [WORD_SIZE-1:0] upd_tgt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = WORD_SIZE - IDX_W;

    logic [TAG_W-1:0]     tag_q [ENTRIES];
    logic [WORD_SIZE-1:0] tgt_q [ENTRIES];
    logic [ENTRIES-1:0]   vld_q;

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;

    assign lk_idx     = lookup_pc[IDX_W-1:0];
    assign up_idx     = upd_pc[IDX_W-1:0];
    assign hit        = vld_q[lk_idx] && (tag_q[lk_idx] == lookup_pc[WORD_SIZE-1:IDX_W]);
    assign hit_target = tgt_q[lk_idx];

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            vld_q <= '0;
        end else if (upd_en) begin
            vld_q[up_idx] <= 1'b1;
        end
    end

    // Tag/target storage needs no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            tag_q[up_idx] <= upd_pc[WORD_SIZE-1:IDX_W];
            tgt_q[up_idx] <= upd_tgt;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory,
// keeps one word in a skid buffer while the pipeline is stalled and
// redirects on EX resolution.
// Optional feature: define IF_FETCH_BTB_EN to compile in the branch target
// buffer (fetch_btb); otherwise the next PC is always pc+1 and the bt_*
// inputs are ignored.
// Ports:
//   clk, reset_n                   : clock, async active-high reset
//   i_readM, i_address             : memory request / address
//   i_data, i_ready                : memory response
//   stall_on                       : hold IF outputs
//   redirect, redirect_pc          : corrected fetch PC from EX
//   bt_update, bt_pc, bt_target    : BTB write port
//   inst_out, pc_out, valid_out    : to IF/ID latch
//   flush_out                      : one-cycle flush after a redirect
//
// state | meaning
// FETCH | request outstanding at pc; accept i_data when i_ready
// HOLD  | stalled with a fetched word parked in the skid buffer
module if_fetch_unit #(
    parameter int WORD_SIZE   = if_fetch_unit_pkg::WORD_SIZE,
    parameter int BTB_ENTRIES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    input  logic                 stall_on,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 bt_update,
    input  logic [WORD_SIZE-1:0] bt_pc,
    input  logic [WORD_SIZE-1:0] bt_target,
    output logic [WORD_SIZE-1:0] inst_out,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic                 valid_out,
    output logic                 flush_out
);
    import if_fetch_unit_pkg::*;

    fetch_state_t         state, state_next;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] npc;
    logic [WORD_SIZE-1:0] skid_inst;
    logic [WORD_SIZE-1:0] skid_pc;

`ifdef IF_FETCH_BTB_EN
    logic                 btb_hit;
    logic [WORD_SIZE-1:0] btb_target;

    fetch_btb #(
        .WORD_SIZE (WORD_SIZE),
        .ENTRIES   (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .reset_n    (reset_n),
        .lookup_pc  (pc),
        .hit        (btb_hit),
        .hit_target (btb_target),
        .upd_en     (bt_update),
        .upd_pc     (bt_pc),
        .upd_tgt    (bt_target)
    );

    assign npc = btb_hit ? btb_target : pc + 1'b1;
`else
    logic unused_bt;
    assign unused_bt = ^{bt_update, bt_pc, bt_target};
    assign npc       = pc + 1'b1;
`endif

    // Request depends only on registered state so stall/redirect never
    // reach the memory interface combinationally.
    assign i_readM   = (state == FETCH) && !reset_n;
    assign i_address = pc;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = FETCH;
        end else begin
            case (state)
                FETCH:   if (i_ready && stall_on) state_next = HOLD;
                HOLD:    if (!stall_on)           state_next = FETCH;
                default: state_next = FETCH;
            endcase
        end
    end

    // The skid buffer is occupied exactly while state is HOLD, so it
    // needs no separate valid flag.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            pc        <= '0;
            inst_out  <= NOP_INST;
            pc_out    <= '0;
            valid_out <= 1'b0;
            flush_out <= 1'b0;
            skid_inst <= NOP_INST;
            skid_pc   <= '0;
        end else begin
            flush_out <= 1'b0;
            if (redirect) begin
                pc        <= redirect_pc;
                inst_out  <= NOP_INST;
                valid_out <= 1'b0;
                flush_out <= 1'b1;
                skid_inst <= NOP_INST;
                skid_pc   <= '0;
            end else begin
                case (state)
                    FETCH: begin
                        if (i_ready) begin
                            pc <= npc;
                            if (stall_on) begin
                                skid_inst <= i_data;
                                skid_pc   <= npc;
                            end else begin
                                inst_out  <= i_data;
                                pc_out    <= npc;
                                valid_out <= 1'b1;
                            end
                        end else if (!stall_on) begin
                            inst_out  <= NOP_INST;
                            valid_out <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall_on) begin
                            inst_out  <= skid_inst;
                            pc_out    <= skid_pc;
                            valid_out <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic        stall_on;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        bt_update;
    logic [15:0] bt_pc;
    logic [15:0] bt_target;
    logic [15:0] inst_out;
    logic [15:0] pc_out;
    logic        valid_out;
    logic        flush_out;

    int checks   = 0;
    int failures = 0;

    localparam logic [15:0] NOP_EXP = 16'hF000;

    always #5 clk = ~clk;

    // Memory returns 16'h6000 + address.
    assign i_data = 16'h6000 + i_address;

    if_fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_readM     (i_readM),
        .i_address   (i_address),
        .i_data      (i_data),
        .i_ready     (i_ready),
        .stall_on    (stall_on),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bt_update   (bt_update),
        .bt_pc       (bt_pc),
        .bt_target   (bt_target),
        .inst_out    (inst_out),
        .pc_out      (pc_out),
        .valid_out   (valid_out),
        .flush_out   (flush_out)
    );

    typedef struct {
        logic        stall;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        e_readm;
        logic [15:0] e_addr;
        logic [15:0] e_inst;
        logic [15:0] e_pc;
        logic        e_valid;
        logic        e_flush;
        logic        chk_pc;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".i_readM"},   {15'b0, i_readM},   16'h0);
        chk({tag, ".i_address"}, i_address,          16'h0);
        chk({tag, ".inst_out"},  inst_out,           NOP_EXP);
        chk({tag, ".pc_out"},    pc_out,             16'h0);
        chk({tag, ".valid_out"}, {15'b0, valid_out}, 16'h0);
        chk({tag, ".flush_out"}, {15'b0, flush_out}, 16'h0);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [15:0] btb_exp_pc;

    initial begin
        // stall rdy redir rpc | readM addr inst pc valid flush chk_pc
        vecs[0]  = '{0,1,0,16'h0000, 1,16'h0001,16'h6000,16'h0001,1,0,1};
        vecs[1]  = '{0,1,0,16'h0000, 1,16'h0002,16'h6001,16'h0002,1,0,1};
        vecs[2]  = '{0,1,0,16'h0000, 1,16'h0003,16'h6002,16'h0003,1,0,1};
        vecs[3]  = '{0,1,0,16'h0000, 1,16'h0004,16'h6003,16'h0004,1,0,1};
        vecs[4]  = '{0,1,0,16'h0000, 1,16'h0005,16'h6004,16'h0005,1,0,1};
        // stall 3 cycles while address 5 is returned
        vecs[5]  = '{1,1,0,16'h0000, 0,16'h0006,16'h6004,16'h0005,1,0,1};
        vecs[6]  = '{1,1,0,16'h0000, 0,16'h0006,16'h6004,16'h0005,1,0,1};
        vecs[7]  = '{1,1,0,16'h0000, 0,16'h0006,16'h6004,16'h0005,1,0,1};
        vecs[8]  = '{0,1,0,16'h0000, 1,16'h0006,16'h6005,16'h0006,1,0,1};
        vecs[9]  = '{0,1,0,16'h0000, 1,16'h0007,16'h6006,16'h0007,1,0,1};
        // redirect with same-cycle ready
        vecs[10] = '{0,1,1,16'h0040, 1,16'h0040,NOP_EXP, 16'h0000,0,1,0};
        vecs[11] = '{0,1,0,16'h0000, 1,16'h0041,16'h6040,16'h0041,1,0,1};
        // two wait cycles per word
        vecs[12] = '{0,0,0,16'h0000, 1,16'h0041,NOP_EXP, 16'h0041,0,0,1};
        vecs[13] = '{0,0,0,16'h0000, 1,16'h0041,NOP_EXP, 16'h0041,0,0,1};
        vecs[14] = '{0,1,0,16'h0000, 1,16'h0042,16'h6041,16'h0042,1,0,1};
        vecs[15] = '{0,0,0,16'h0000, 1,16'h0042,NOP_EXP, 16'h0042,0,0,1};
        vecs[16] = '{0,0,0,16'h0000, 1,16'h0042,NOP_EXP, 16'h0042,0,0,1};
        vecs[17] = '{0,1,0,16'h0000, 1,16'h0043,16'h6042,16'h0043,1,0,1};
        // redirect to FFFF, PC wraps
        vecs[18] = '{0,1,1,16'hFFFF, 1,16'hFFFF,NOP_EXP, 16'h0000,0,1,0};
        vecs[19] = '{0,1,0,16'h0000, 1,16'h0000,16'h5FFF,16'h0000,1,0,1};
        // stall without ready keeps valid; no stall drops it
        vecs[20] = '{1,0,0,16'h0000, 1,16'h0000,16'h5FFF,16'h0000,1,0,1};
        vecs[21] = '{0,0,0,16'h0000, 1,16'h0000,NOP_EXP, 16'h0000,0,0,1};
        // redirect while in HOLD discards the skid word
        vecs[22] = '{1,1,0,16'h0000, 0,16'h0001,NOP_EXP, 16'h0000,0,0,1};
        vecs[23] = '{1,1,1,16'h0010, 1,16'h0010,NOP_EXP, 16'h0000,0,1,0};
        vecs[24] = '{0,1,0,16'h0000, 1,16'h0011,16'h6010,16'h0011,1,0,1};

        reset_n     = 1'b1;
        i_ready     = 1'b0;
        stall_on    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        bt_update   = 1'b0;
        bt_pc       = '0;
        bt_target   = '0;

        cycle();
        cycle();
        check_reset_vals("reset");
        reset_n = 1'b0;
        #1;
        chk("post_reset.i_readM", {15'b0, i_readM}, 16'h1);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            stall_on    = vecs[i].stall;
            i_ready     = vecs[i].rdy;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            cycle();
            chk($sformatf("v%0d.i_readM", i),   {15'b0, i_readM},   {15'b0, vecs[i].e_readm});
            chk($sformatf("v%0d.i_address", i), i_address,          vecs[i].e_addr);
            chk($sformatf("v%0d.inst_out", i),  inst_out,           vecs[i].e_inst);
            if (vecs[i].chk_pc)
                chk($sformatf("v%0d.pc_out", i), pc_out, vecs[i].e_pc);
            chk($sformatf("v%0d.valid_out", i), {15'b0, valid_out}, {15'b0, vecs[i].e_valid});
            chk($sformatf("v%0d.flush_out", i), {15'b0, flush_out}, {15'b0, vecs[i].e_flush});
        end
        redirect = 1'b0;
        stall_on = 1'b0;

        // BTB: record branch at 3 -> 0x20, redirect to 3, then fetch it.
`ifdef IF_FETCH_BTB_EN
        btb_exp_pc = 16'h0020;
`else
        btb_exp_pc = 16'h0004;
`endif
        bt_update   = 1'b1;
        bt_pc       = 16'h0003;
        bt_target   = 16'h0020;
        redirect    = 1'b1;
        redirect_pc = 16'h0003;
        i_ready     = 1'b1;
        cycle();
        bt_update = 1'b0;
        redirect  = 1'b0;
        chk("btb.redir_addr", i_address, 16'h0003);
        chk("btb.flush", {15'b0, flush_out}, 16'h1);
        cycle();
        chk("btb.inst_out", inst_out, 16'h6003);
        chk("btb.pc_out", pc_out, btb_exp_pc);
        chk("btb.next_addr", i_address, btb_exp_pc);

        // Reset asserted asynchronously while in HOLD.
        stall_on = 1'b1;
        cycle();
        chk("hold.i_readM", {15'b0, i_readM}, 16'h0);
        #2;
        reset_n = 1'b1;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        reset_n  = 1'b0;
        stall_on = 1'b0;
        i_ready  = 1'b1;
        cycle();
        chk("after_reset.inst_out", inst_out, 16'h6000);
        chk("after_reset.pc_out", pc_out, 16'h0001);
        chk("after_reset.valid_out", {15'b0, valid_out}, 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 16-bit pipelined CPU. It sits directly upstream of the IF/ID latch, which it feeds through `inst_out`/`pc_out`. The block owns the architectural PC, runs the request/ready handshake with instruction memory, and holds one fetched word in a skid buffer while the pipeline is stalled. It redirects on branch/jump resolution from EX and can optionally predict taken branches with a small BTB.

## Interface
Parameters:
- `WORD_SIZE`, 16: datapath and address width.
- `BTB_ENTRIES`, 4: BTB entries, a power of two; used only with `BTB_EN`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-high reset. The name is kept for codebase consistency; level 1 resets.
- `i_readM` out 1: instruction-memory read request.
- `i_address` out 16: fetch address.
- `i_data` in 16: instruction word; valid when `i_ready`=1.
- `i_ready` in 1: memory response strobe, sampled on the rising edge.
- `stall_on` in 1: hazard unit holds the IF outputs.
- `redirect` in 1: EX resolved a mispredict, jump or branch.
- `redirect_pc` in 16: corrected fetch PC.
- `bt_update` in 1: BTB write strobe from EX.
- `bt_pc` in 16: PC of the taken branch to record.
- `bt_target` in 16: target of the taken branch to record.
- `inst_out` out 16: fetched instruction, to `IFID.inst_in`.
- `pc_out` out 16: predicted next PC for that instruction, to `IFID.pc_in`.
- `valid_out` out 1: `inst_out` holds a real instruction.
- `flush_out` out 1: one-cycle pulse after a redirect, to `IFID.flush_on`.

## Operation
- State machine states: FETCH, HOLD.
- Reset values:
  - `pc`=0, state FETCH.
  - `i_readM`=0 while reset is held; `i_address`=0.
  - `inst_out`={NOP_OP,12'b0}, `pc_out`=0, `valid_out`=0, `flush_out`=0.
  - Skid buffer empty; all BTB valid bits 0.
- FETCH: `i_readM`=1 and `i_address`=`pc`, both combinational from state.
  - On `i_ready` with `stall_on`=0: `inst_out`←`i_data`, `pc_out`←`npc`, `valid_out`←1, `pc`←`npc`.
  - On `i_ready` with `stall_on`=1: the word and its `npc` go to the skid buffer, `pc`←`npc`, state→HOLD.
  - With no `i_ready`, `valid_out` stays 1 only while `stall_on`=1; otherwise it drops to 0 and `inst_out` becomes NOP.
- HOLD: `i_readM`=0; the outputs keep their values.
  - On the first cycle with `stall_on`=0, the skid buffer moves to the outputs and state→FETCH.
- `npc` = BTB target on a hit, else `pc`+1, modulo 2^16 (16'hFFFF+1 = 0).
- Redirect has the highest priority over `i_ready`, `stall_on` and HOLD:
  - `pc`←`redirect_pc`; skid buffer cleared; any same-cycle `i_ready` data dropped.
  - Next cycle: `inst_out`=NOP, `valid_out`=0, `flush_out`=1 for exactly one cycle; state→FETCH.
- BTB update on `bt_update`:
  - Entry indexed by `bt_pc[log2(BTB_ENTRIES)-1:0]`, tag = the remaining upper bits.
  - Written with valid=1 and `bt_target`.
  - An update to the index currently being fetched becomes visible on the next cycle, not the same cycle.
- Reset asserted mid-fetch: everything returns to reset values immediately; the abandoned memory response is ignored.

## Timing
- Zero-wait memory (`i_ready`=1 in the same cycle as `i_readM`): one instruction per cycle; `inst_out` is valid the cycle after the request.
- N wait cycles produce N bubble cycles (`valid_out`=0).
- Redirect-to-first-valid latency: 2 cycles with zero-wait memory (1 bubble + 1 fetch).
- Skid-to-output latency: the same edge on which `stall_on` falls.
- `stall_on` and `redirect` are sampled on the rising edge. They come from the same-cycle hazard/EX logic, so no combinational path runs from them to `i_readM`.

## Configuration
- `IF_FETCH_BTB_EN` defined: the BTB and its `bt_*` update path are compiled in; `npc` uses the hit target.
- Not defined: no BTB storage; `npc`=`pc`+1 always; the `bt_*` inputs remain as ports but are ignored.

## Structure
- Shared package (alongside `opcodes.v`) holds:
  - `WORD_SIZE`
  - the NOP encoding {NOP_OP,12'b0}
  - the FETCH/HOLD state encoding
- One sub-module, `fetch_btb`: direct-mapped tag/target/valid array with combinational lookup and a synchronous update port. It is instantiated only under `IF_FETCH_BTB_EN`.

## Test plan
- Reset, zero-wait memory returning 16'h6000+addr: the output sequence is addresses 0,1,2,3 with `pc_out` 1,2,3,4; `valid_out` is 1 from the second cycle.
- `stall_on` high for 3 cycles while `i_ready`=1 at address 5: the outputs hold, `i_readM`=0 in HOLD, and the word from address 5 appears as the stall drops; no word is lost or duplicated.
- `redirect`=1 with `redirect_pc`=16'h0040 in the same cycle as `i_ready`: that data is dropped; next cycle NOP, `valid_out`=0, `flush_out`=1; then the address 16'h0040 fetch.
- Memory with 2 wait cycles: 2 bubbles per instruction, and `i_address` stays stable until `i_ready`.
- With `IF_FETCH_BTB_EN`: `bt_update` with `bt_pc`=3, `bt_target`=16'h0020; the next fetch of PC 3 gives `pc_out`=16'h0020. Without the macro, `pc_out`=4.
- `redirect_pc`=16'hFFFF: next `pc_out`=0 (wrap); reset asserted while in HOLD returns all outputs to their reset values immediately.
